// File: rtl/decode_if.sv
// Decode-stage port bundle: fetch handshake, register-file read/snoop, execute entry.
// The slave side belongs to decode_stage; the master side is fetch/regfile/execute.
interface decode_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_instr;
  logic [DATA_WIDTH-1:0] i_pc;
  logic                  i_flush;
  logic [ADDR_WIDTH-1:0] o_rd_addr_1;
  logic [ADDR_WIDTH-1:0] o_rd_addr_2;
  logic [DATA_WIDTH-1:0] i_rd_data_1;
  logic [DATA_WIDTH-1:0] i_rd_data_2;
  logic                  i_wb_we;
  logic [ADDR_WIDTH-1:0] i_wb_addr;
  logic [DATA_WIDTH-1:0] i_wb_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_pc;
  logic [DATA_WIDTH-1:0] o_rs1_val;
  logic [DATA_WIDTH-1:0] o_rs2_val;
  logic [DATA_WIDTH-1:0] o_imm;
  logic [ADDR_WIDTH-1:0] o_rd;
  logic [6:0]            o_opcode;
  logic [2:0]            o_funct3;
  logic                  o_funct7b5;
  logic                  o_illegal;

  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_rd_data_1, i_rd_data_2,
           i_wb_we, i_wb_addr, i_wb_data, i_ready,
    output o_ready, o_rd_addr_1, o_rd_addr_2, o_valid, o_pc, o_rs1_val,
           o_rs2_val, o_imm, o_rd, o_opcode, o_funct3, o_funct7b5, o_illegal
  );

  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_rd_data_1, i_rd_data_2,
           i_wb_we, i_wb_addr, i_wb_data, i_ready,
    input  o_ready, o_rd_addr_1, o_rd_addr_2, o_valid, o_pc, o_rs1_val,
           o_rs2_val, o_imm, o_rd, o_opcode, o_funct3, o_funct7b5, o_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode/operand-fetch stage with a single-entry output register.
// Define WB_BYPASS_EN to forward regfile writebacks into accepted and held operands.
module decode_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  decode_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;

  logic [31:0]           instr;
  logic [6:0]            opcode;
  logic [ADDR_WIDTH-1:0] rs1_a, rs2_a;
  logic [DATA_WIDTH-1:0] imm;
  logic [ADDR_WIDTH-1:0] rd;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] rs1_cap, rs2_cap;
  logic                  accept;

  assign instr  = bus.i_instr;
  assign opcode = instr[6:0];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];

  assign bus.o_rd_addr_1 = rs1_a;
  assign bus.o_rd_addr_2 = rs2_a;
  assign bus.o_ready     = !bus.o_valid || bus.i_ready;
  assign accept          = bus.i_valid && bus.o_ready && !bus.i_flush;

  always_comb begin
    imm     = '0;
    rd      = instr[11:7];
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE: begin
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        rd  = '0;
      end
      OP_BRANCH: begin
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        rd  = '0;
      end
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_OP, OP_MISC:
        imm = '0;
      default: begin
        illegal = 1'b1;
        rd      = '0;
      end
    endcase
  end

`ifdef WB_BYPASS_EN
  logic [ADDR_WIDTH-1:0] held_a1, held_a2;
  logic                  hit1, hit2, held_hit1, held_hit2;

  assign hit1      = bus.i_wb_we && (bus.i_wb_addr == rs1_a);
  assign hit2      = bus.i_wb_we && (bus.i_wb_addr == rs2_a);
  assign held_hit1 = bus.i_wb_we && (bus.i_wb_addr == held_a1) && (held_a1 != '0);
  assign held_hit2 = bus.i_wb_we && (bus.i_wb_addr == held_a2) && (held_a2 != '0);
  assign rs1_cap   = (rs1_a == '0) ? '0 : (hit1 ? bus.i_wb_data : bus.i_rd_data_1);
  assign rs2_cap   = (rs2_a == '0) ? '0 : (hit2 ? bus.i_wb_data : bus.i_rd_data_2);
`else
  logic unused_wb;

  assign unused_wb = ^{bus.i_wb_we, bus.i_wb_addr, bus.i_wb_data};
  assign rs1_cap   = (rs1_a == '0) ? '0 : bus.i_rd_data_1;
  assign rs2_cap   = (rs2_a == '0) ? '0 : bus.i_rd_data_2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid    <= 1'b0;
      bus.o_pc       <= '0;
      bus.o_rs1_val  <= '0;
      bus.o_rs2_val  <= '0;
      bus.o_imm      <= '0;
      bus.o_rd       <= '0;
      bus.o_opcode   <= '0;
      bus.o_funct3   <= '0;
      bus.o_funct7b5 <= 1'b0;
      bus.o_illegal  <= 1'b0;
`ifdef WB_BYPASS_EN
      held_a1        <= '0;
      held_a2        <= '0;
`endif
    end else if (bus.i_flush) begin
      bus.o_valid <= 1'b0;
    end else if (accept) begin
      bus.o_valid    <= 1'b1;
      bus.o_pc       <= bus.i_pc;
      bus.o_rs1_val  <= rs1_cap;
      bus.o_rs2_val  <= rs2_cap;
      bus.o_imm      <= imm;
      bus.o_rd       <= rd;
      bus.o_opcode   <= opcode;
      bus.o_funct3   <= instr[14:12];
      bus.o_funct7b5 <= instr[30];
      bus.o_illegal  <= illegal;
`ifdef WB_BYPASS_EN
      held_a1        <= rs1_a;
      held_a2        <= rs2_a;
`endif
    end else if (bus.i_ready) begin
      bus.o_valid <= 1'b0;
    end
`ifdef WB_BYPASS_EN
    // Held entry: late writebacks refresh the stalled operands in place.
    else begin
      if (held_hit1) bus.o_rs1_val <= bus.i_wb_data;
      if (held_hit2) bus.o_rs2_val <= bus.i_wb_data;
    end
`endif
  end
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases plus randomized traffic
// checked against a behavioural RV32I decode model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
  decode_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [31:0] regs [32];
  assign bus.i_rd_data_1 = regs[bus.o_rd_addr_1];
  assign bus.i_rd_data_2 = regs[bus.o_rd_addr_2];

  typedef struct packed {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd, a1, a2;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, ill;
  } exp_t;

  exp_t q[$];
  bit   mv = 1'b0;
  bit   chk_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [144:0] obs();
    return {bus.o_pc, bus.o_rs1_val, bus.o_rs2_val, bus.o_imm, bus.o_rd,
            bus.o_opcode, bus.o_funct3, bus.o_funct7b5, bus.o_illegal};
  endfunction

  function automatic logic [144:0] pack(input exp_t e);
    return {e.pc, e.rs1, e.rs2, e.imm, e.rd, e.op, e.f3, e.f7, e.ill};
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return regs[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    e     = '0;
    e.pc  = pc;
    e.op  = ins[6:0];
    e.f3  = ins[14:12];
    e.f7  = ins[30];
    e.a1  = ins[19:15];
    e.a2  = ins[24:20];
    e.rd  = ins[11:7];
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: e.imm = 32'($signed(ins[31:20]));
      7'h23: begin e.imm = 32'($signed({ins[31:25], ins[11:7]})); e.rd = 5'd0; end
      7'h63: begin
        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) << 1;
        e.rd  = 5'd0;
      end
      7'h37, 7'h17: e.imm = ins & 32'hFFFFF000;
      7'h6F: e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) << 1;
      7'h33, 7'h0F: e.imm = 32'd0;
      default: begin e.ill = 1'b1; e.rd = 5'd0; e.imm = 32'd0; end
    endcase
    e.rs1 = operand(e.a1, we, wa, wd);
    e.rs2 = operand(e.a2, we, wa, wd);
    return e;
  endfunction

  // Reference model: advances the expected entry state at each active edge.
  always @(posedge clk) begin
    exp_t h;
    if (rst) begin
      q.delete();
      mv = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + 32'(i * 17);
    end else begin
      if (bus.i_flush) begin
        if (mv && !bus.i_ready && q.size() > 0) void'(q.pop_front());
        mv = 1'b0;
      end else if (bus.i_valid && (!mv || bus.i_ready)) begin
        q.push_back(model(bus.i_instr, bus.i_pc, bus.i_wb_we, bus.i_wb_addr, bus.i_wb_data));
        mv = 1'b1;
      end else if (bus.i_ready) begin
        mv = 1'b0;
      end else if (mv && q.size() > 0) begin
`ifdef WB_BYPASS_EN
        h = q[0];
        if (bus.i_wb_we && bus.i_wb_addr != 5'd0) begin
          if (bus.i_wb_addr == h.a1) h.rs1 = bus.i_wb_data;
          if (bus.i_wb_addr == h.a2) h.rs2 = bus.i_wb_data;
        end
        q[0] = h;
`endif
      end
      if (bus.i_wb_we) regs[bus.i_wb_addr] <= bus.i_wb_data;
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", 160'(bus.o_valid), 160'(mv));
      check("o_ready", 160'(bus.o_ready), 160'(!mv || bus.i_ready));
      check("rd_addr", 160'({bus.o_rd_addr_1, bus.o_rd_addr_2}),
            160'({bus.i_instr[19:15], bus.i_instr[24:20]}));
      if (bus.o_valid) begin
        if (q.size() == 0) begin
          check("entry_unexpected", 160'(obs()), 160'hDEAD_0000);
        end else begin
          check("entry", 160'(obs()), 160'(pack(q[0])));
          if (bus.i_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic rdy, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.i_valid   = v;
    bus.i_instr   = ins;
    bus.i_pc      = pc;
    bus.i_flush   = fl;
    bus.i_ready   = rdy;
    bus.i_wb_we   = we;
    bus.i_wb_addr = wa;
    bus.i_wb_data = wd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 11))
      0: ins[6:0] = 7'h03;   1: ins[6:0] = 7'h13;   2: ins[6:0] = 7'h67;
      3: ins[6:0] = 7'h73;   4: ins[6:0] = 7'h23;   5: ins[6:0] = 7'h63;
      6: ins[6:0] = 7'h37;   7: ins[6:0] = 7'h17;   8: ins[6:0] = 7'h6F;
      9: ins[6:0] = 7'h33;  10: ins[6:0] = 7'h0F;
      default: ;
    endcase
    return ins;
  endfunction

  localparam logic [31:0] ADDI = 32'hFFF08293;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] JAL  = 32'h001000EF;
  localparam logic [31:0] ADD2 = 32'h002101B3;
  localparam logic [31:0] ADD0 = 32'h000001B3;

  initial begin
    rst = 1'b1;
    drive(1, ADDI, 32'h40, 0, 1, 0, 0, 0);
    chk_en = 1'b1;
    drive(1, ADDI, 32'h44, 0, 1, 0, 0, 0);
    check("reset_valid", 160'(bus.o_valid), 160'd0);
    check("reset_outputs", 160'(obs()), 160'd0);
    rst = 1'b0;

    drive(0, 32'h0, 32'h0, 0, 1, 1, 5'd1, 32'd7);
    drive(1, ADDI, 32'h100, 0, 1, 0, 0, 0);
    check("addi_valid", 160'(bus.o_valid), 160'd1);
    check("addi_imm", 160'(bus.o_imm), 160'hFFFFFFFF);
    check("addi_rd", 160'(bus.o_rd), 160'd5);
    check("addi_rs1", 160'(bus.o_rs1_val), 160'd7);

    drive(1, BEQ, 32'h104, 0, 1, 0, 0, 0);
    check("beq_imm", 160'(bus.o_imm), 160'hFFFFFFFC);
    check("beq_rd", 160'(bus.o_rd), 160'd0);
    drive(1, JAL, 32'h108, 0, 1, 0, 0, 0);
    check("jal_imm", 160'(bus.o_imm), 160'h00000800);
    drive(1, 32'hFFFFFFFF, 32'h10C, 0, 1, 0, 0, 0);
    check("illegal_flag", 160'(bus.o_illegal), 160'd1);
    check("illegal_imm", 160'(bus.o_imm), 160'd0);

    drive(1, ADDI, 32'h200, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, BEQ, 32'h204, 0, 0, 0, 0, 0);
      check("hold_ready", 160'(bus.o_ready), 160'd0);
      check("hold_pc", 160'(bus.o_pc), 160'h200);
    end
    drive(1, BEQ, 32'h204, 0, 1, 0, 0, 0);
    check("release_pc", 160'(bus.o_pc), 160'h204);

    drive(0, 32'h0, 32'h0, 0, 1, 1, 5'd2, 32'h1234);
    drive(1, ADD2, 32'h300, 0, 1, 1, 5'd2, 32'hDEAD);
`ifdef WB_BYPASS_EN
    check("bypass_ops", 160'({bus.o_rs1_val, bus.o_rs2_val}), 160'({32'hDEAD, 32'hDEAD}));
`else
    check("stale_ops", 160'({bus.o_rs1_val, bus.o_rs2_val}), 160'({32'h1234, 32'h1234}));
`endif
    drive(1, ADD0, 32'h304, 0, 1, 1, 5'd0, 32'd5);
    check("x0_ops", 160'({bus.o_rs1_val, bus.o_rs2_val}), 160'd0);

    drive(1, ADDI, 32'h400, 0, 1, 0, 0, 0);
    drive(1, JAL, 32'h404, 1, 0, 0, 0, 0);
    check("flush_valid", 160'(bus.o_valid), 160'd0);
    drive(0, 32'h0, 32'h0, 0, 1, 0, 0, 0);
    check("flush_dropped", 160'(bus.o_valid), 160'd0);

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) < 7), rand_instr(), $urandom, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom);
    end

    for (int n = 0; n < 4; n++) drive(0, 32'h0, 32'h0, 0, 1, 0, 0, 0);
    check("drain_queue", 160'(q.size()), 160'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
